// File: rtl/dmem_wait_pkg.sv
// Shared definitions for the latency-configurable data memory: FSM state codes,
// default geometry, the latched-request record and a width helper.
package dmem_wait_pkg;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefDepth = 64;

   typedef struct packed {
      logic rd;
      logic wr;
      logic fault;
   } req_t;

   // Bit width needed to hold values below n, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled word array with a combinational read port and a clocked write port.
// Contents are never reset.
module dmem_bank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    widx_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wbe_i,
   input  logic [IDX_W-1:0]    ridx_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mcell [0:DEPTH-1];

   logic wr_in_range;
   logic rd_in_range;

   // Guards matter only when DEPTH is not a power of two.
   assign wr_in_range = 32'(widx_i) < DEPTH;
   assign rd_in_range = 32'(ridx_i) < DEPTH;

   always_ff @(posedge clk_i) begin
      if (we_i && wr_in_range) begin
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (wbe_i[i]) begin
               mcell[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = rd_in_range ? mcell[ridx_i] : '0;

endmodule

// File: rtl/dmem_wait.sv
// Data memory for the MIPS core with configurable access latency, byte-enable
// writes and fault flagging; stalls the core while an access is outstanding.
module dmem_wait
   import dmem_wait_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned LATENCY = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wrdata,
   input  logic [DATA_W/8-1:0] byteen,
   input  logic                MemRead,
   input  logic                MemWrite,
   output logic [DATA_W-1:0]   rddata,
   output logic                rdvalid,
   output logic                stall,
   output logic                err
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned IDX_W = clog2_min1(DEPTH);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  req_idx;
   logic              req_fault;

   assign word_idx  = addr >> OFF_W;
   assign req_idx   = word_idx[IDX_W-1:0];
   assign req_fault = (|(addr & OFF_MASK)) | (word_idx >= DEPTH_A) | (MemRead & MemWrite);

   logic              bank_we;
   logic [IDX_W-1:0]  bank_widx;
   logic [IDX_W-1:0]  bank_ridx;
   logic [DATA_W-1:0] bank_wdata;
   logic [BE_W-1:0]   bank_wbe;
   logic [DATA_W-1:0] bank_rdata;

   dmem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) bank (
      .clk_i   (clock),
      .we_i    (bank_we),
      .widx_i  (bank_widx),
      .wdata_i (bank_wdata),
      .wbe_i   (bank_wbe),
      .ridx_i  (bank_ridx),
      .rdata_o (bank_rdata)
   );

   if (LATENCY == 0) begin : g_comb
      assign bank_we    = MemWrite & ~req_fault & ~reset;
      assign bank_widx  = req_idx;
      assign bank_ridx  = req_idx;
      assign bank_wdata = wrdata;
      assign bank_wbe   = byteen;

      assign stall   = 1'b0;
      assign rdvalid = MemRead & ~req_fault;
      assign rddata  = rdvalid ? bank_rdata : '0;
      assign err     = req_fault & (MemRead | MemWrite);
   end else begin : g_fsm
      localparam int unsigned CNT_W = clog2_min1(LATENCY);

      logic [1:0]        state_q, state_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [IDX_W-1:0]  idx_q;
      logic [DATA_W-1:0] wdata_q;
      logic [BE_W-1:0]   be_q;
      req_t              req_q;
      logic              req;
      logic              load;
      logic              in_done;

      assign req     = (MemRead | MemWrite) & ~reset;
      assign load    = (state_q == StIdle) & req;
      assign in_done = (state_q == StDone);

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            StIdle: begin
               if (req) begin
                  if (LATENCY == 1) begin
                     state_d = StDone;
                  end else begin
                     state_d = StWait;
                     cnt_d   = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
                  end
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Request payload needs no reset: it is only observed in StDone.
      always_ff @(posedge clock) begin
         if (load) begin
            idx_q   <= req_idx;
            wdata_q <= wrdata;
            be_q    <= byteen;
            req_q   <= '{rd: MemRead, wr: MemWrite, fault: req_fault};
         end
      end

      assign bank_we    = in_done & req_q.wr & ~req_q.fault & ~reset;
      assign bank_widx  = idx_q;
      assign bank_ridx  = idx_q;
      assign bank_wdata = wdata_q;
      assign bank_wbe   = be_q;

      assign stall   = load | (state_q == StWait);
      assign rdvalid = in_done & req_q.rd & ~req_q.fault;
      assign rddata  = rdvalid ? bank_rdata : '0;
      assign err     = in_done & req_q.fault;
   end

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: directed vector table and random accesses against a word-array
// model on a LATENCY=2 instance, plus a store/load loop on a LATENCY=0 instance.
module tb_dmem_wait;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic [31:0] addr = '0, wrdata = '0;
   logic [3:0]  byteen = '0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] rddata;
   logic        rdvalid, stall, err;

   logic [31:0] addr0 = '0, wrdata0 = '0;
   logic [3:0]  byteen0 = '0;
   logic        MemRead0 = 1'b0, MemWrite0 = 1'b0;
   logic [31:0] rddata0;
   logic        rdvalid0, stall0, err0;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [DEPTH];

   always #5 clock = ~clock;

   dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .addr(addr), .wrdata(wrdata), .byteen(byteen),
      .MemRead(MemRead), .MemWrite(MemWrite), .rddata(rddata), .rdvalid(rdvalid),
      .stall(stall), .err(err)
   );

   dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clock(clock), .reset(reset), .addr(addr0), .wrdata(wrdata0), .byteen(byteen0),
      .MemRead(MemRead0), .MemWrite(MemWrite0), .rddata(rddata0), .rdvalid(rdvalid0),
      .stall(stall0), .err(err0)
   );

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        ev;
      logic [31:0] eq;
      logic        ee;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input int i, input logic [31:0] v);
      dut.bank.mcell[i] = v;
      model[i] = v;
   endtask

   // One access on the latency DUT; inputs are scrambled while the access is in flight.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int stalls,
                         output logic v, output logic [31:0] q, output logic e);
      @(negedge clock);
      MemRead = rd; MemWrite = wr; addr = a; wrdata = d; byteen = be;
      stalls = 0;
      #1;
      while (stall && stalls < 20) begin
         stalls++;
         @(negedge clock);
         addr = $urandom; wrdata = $urandom; byteen = 4'($urandom);
         MemRead = 1'($urandom); MemWrite = 1'($urandom);
         #1;
      end
      v = rdvalid; q = rddata; e = err;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clock);
   endtask

   task automatic access0(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, output logic s,
                          output logic v, output logic [31:0] q, output logic e);
      @(negedge clock);
      MemRead0 = rd; MemWrite0 = wr; addr0 = a; wrdata0 = d; byteen0 = be;
      #1;
      s = stall0; v = rdvalid0; q = rddata0; e = err0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int          st;
      logic        v, e, s, stall_seen;
      logic [31:0] q, acc, exp_q;

      vecs[0]  = '{1'b1, 1'b0, 32'd4,   32'd0,          4'hF, 1'b1, 32'd56,         1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'd12,  32'd560,        4'hF, 1'b0, 32'd0,          1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'd12,  32'd0,          4'hF, 1'b1, 32'd560,        1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'd0,   32'hAABBCCDD,   4'h2, 1'b0, 32'd0,          1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'd0,   32'd0,          4'h0, 1'b1, 32'h1122CC44,   1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'd6,   32'd0,          4'h0, 1'b0, 32'd0,          1'b1};
      vecs[6]  = '{1'b0, 1'b1, 32'd256, 32'd77,         4'hF, 1'b0, 32'd0,          1'b1};
      vecs[7]  = '{1'b1, 1'b1, 32'd4,   32'd1,          4'hF, 1'b0, 32'd0,          1'b1};
      vecs[8]  = '{1'b1, 1'b0, 32'd4,   32'd0,          4'h0, 1'b1, 32'd56,         1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'd16,  32'hFFFFFFFF,   4'h0, 1'b0, 32'd0,          1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'd16,  32'd0,          4'h0, 1'b1, 32'd0,          1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'd252, 32'd0,          4'h0, 1'b1, 32'd0,          1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'd0,   32'd0,          4'h0, 1'b1, 32'h1122CC44,   1'b0};

      for (int i = 0; i < DEPTH; i++) preload(i, 32'd0);
      preload(0, 32'h11223344);
      preload(1, 32'd56);
      preload(2, 32'h00005555);

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_rdvalid", 32'(rdvalid), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_rddata", rddata, 32'd0);
      chk("reset_stall0", 32'(stall0), 32'd0);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, st, v, q, e);
         chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(LAT));
         chk($sformatf("vec%0d_rdvalid", i), 32'(v), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_rddata", i), q, vecs[i].eq);
         chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].ee));
         if (i == 1) begin
            #1;
            chk("vec1_mcell3", dut.bank.mcell[3], 32'd560);
         end
      end
      chk("fault_no_wrap_mcell0", dut.bank.mcell[0], 32'h1122CC44);
      chk("rw_fault_mcell1", dut.bank.mcell[1], 32'd56);

      // Reset during WAIT of a write drops it
      @(negedge clock);
      MemWrite = 1'b1; addr = 32'd8; wrdata = 32'd99; byteen = 4'hF;
      #1;
      chk("rstw_req_stall", 32'(stall), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rstw_wait_stall", 32'(stall), 32'd1);
      @(negedge clock);
      reset = 1'b0; MemWrite = 1'b0;
      #1;
      chk("rstw_after_stall", 32'(stall), 32'd0);
      chk("rstw_after_err", 32'(err), 32'd0);
      @(posedge clock);
      #1;
      chk("rstw_mcell2", dut.bank.mcell[2], 32'h00005555);

      // Reset during DONE of a write drops it too
      @(negedge clock);
      MemWrite = 1'b1; addr = 32'd8; wrdata = 32'd123; byteen = 4'hF;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; MemWrite = 1'b0;
      @(posedge clock);
      #1;
      chk("rstd_mcell2", dut.bank.mcell[2], 32'h00005555);

      // Randomized accesses against the model
      for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
      for (int n = 0; n < 60; n++) begin
         logic        rd, wr, fault, exp_v;
         logic [31:0] a, d;
         logic [3:0]  be;
         int          sel;
         sel = int'($urandom_range(0, 15));
         rd = (sel < 7) || (sel == 15);
         wr = (sel >= 7);
         a = $urandom_range(0, DEPTH - 1) * 4;
         if (sel == 3 || sel == 9) a = a + $urandom_range(1, 3);
         if (sel == 5 || sel == 11) a = (DEPTH + $urandom_range(0, 1000)) * 4;
         d = $urandom;
         be = 4'($urandom);
         fault = (a % 4 != 0) || (a / 4 >= DEPTH) || (rd && wr);
         exp_v = rd && !fault;
         exp_q = exp_v ? model[a / 4] : 32'd0;
         if (wr && !fault) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
         end
         access(rd, wr, a, d, be, st, v, q, e);
         chk($sformatf("rnd%0d_stalls", n), 32'(st), 32'(LAT));
         chk($sformatf("rnd%0d_rdvalid", n), 32'(v), 32'(exp_v));
         chk($sformatf("rnd%0d_rddata", n), q, exp_q);
         chk($sformatf("rnd%0d_err", n), 32'(e), 32'(fault));
      end
      #1;
      for (int i = 0; i < DEPTH; i++) chk($sformatf("sweep_mcell%0d", i), dut.bank.mcell[i], model[i]);

      // Zero-latency instance: store 56, then accumulate it ten times into mcell[3]
      stall_seen = 1'b0;
      access0(1'b0, 1'b1, 32'd4, 32'd56, 4'hF, s, v, q, e);
      stall_seen |= s;
      access0(1'b0, 1'b1, 32'd12, 32'd0, 4'hF, s, v, q, e);
      stall_seen |= s;
      acc = 32'd0;
      for (int k = 0; k < 10; k++) begin
         access0(1'b1, 1'b0, 32'd4, 32'd0, 4'h0, s, v, q, e);
         stall_seen |= s;
         chk($sformatf("lat0_ld%0d_rdvalid", k), 32'(v), 32'd1);
         acc = acc + q;
         access0(1'b0, 1'b1, 32'd12, acc, 4'hF, s, v, q, e);
         stall_seen |= s;
      end
      access0(1'b1, 1'b0, 32'd12, 32'd0, 4'h0, s, v, q, e);
      chk("lat0_final_rddata", q, 32'd560);
      chk("lat0_final_rdvalid", 32'(v), 32'd1);
      access0(1'b1, 1'b0, 32'd2, 32'd0, 4'h0, s, v, q, e);
      chk("lat0_misalign_err", 32'(e), 32'd1);
      chk("lat0_misalign_rdvalid", 32'(v), 32'd0);
      chk("lat0_misalign_rddata", q, 32'd0);
      access0(1'b0, 1'b1, 32'd4 * DEPTH, 32'd7, 4'hF, s, v, q, e);
      chk("lat0_oor_err", 32'(e), 32'd1);
      @(negedge clock);
      MemRead0 = 1'b0; MemWrite0 = 1'b0;
      #1;
      chk("lat0_mcell3", dut0.bank.mcell[3], 32'd560);
      chk("lat0_mcell0_untouched", 32'(dut0.bank.mcell[0] == 32'd7), 32'd0);
      chk("lat0_stall_never", 32'(stall_seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
